// File: rtl/segre_pkg.sv
// Shared types and constants for the segre TLB subsystem: page protection
// encoding, walker FSM states, requester ids and PTE field positions.
package segre_pkg;

    // Default page-number widths for the TLBs and the walker.
    localparam int VADDR_SIZE = 20;
    localparam int PADDR_SIZE = 20;

    // PTE layout: valid flag on top, protection just below it, PPN in the LSBs.
    localparam int PTE_VALID_BIT = 31;
    localparam int PTE_PROT_LSB  = 29;

    typedef enum logic [1:0] {
        PROT_RW   = 2'b00,
        PROT_R    = 2'b01,
        PROT_RX   = 2'b10,
        PROT_NONE = 2'b11
    } page_protection_e;

    typedef enum logic [2:0] {
        TW_IDLE     = 3'd0,
        TW_MEM_REQ  = 3'd1,
        TW_MEM_WAIT = 3'd2,
        TW_FILL     = 3'd3,
        TW_FLUSH    = 3'd4
    } tlb_walker_state_e;

    typedef enum logic {
        ITLB = 1'b0,
        DTLB = 1'b1
    } tlb_req_id_e;

endpackage

// File: rtl/segre_tlb_walker_if.sv
// Memory-side port of the TLB walker: a single outstanding PTE read with a
// request/grant handshake followed by a response valid.
interface segre_tlb_walker_if #(
    parameter int ADDR_SIZE = 32
);
    logic                 mem_req;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [ADDR_SIZE-1:0] mem_rdata;

    // The walker issues reads.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    // The memory arbiter answers them.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/segre_rr_arbiter2.sv
// Two-requester round-robin arbiter (bit 0 = ITLB, bit 1 = DTLB). A masked
// requester is ignored; on a tie the side not granted last time wins.
module segre_rr_arbiter2
    import segre_pkg::*;
(
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  mask_i,
    input  logic        accept_i,
    output logic        valid_o,
    output tlb_req_id_e id_o
);

    tlb_req_id_e last_grant_q, last_grant_d;
    logic [1:0]  eligible;

    // Pick a winner among the unmasked requesters.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        eligible = req_i & ~mask_i;
        valid_o  = |eligible;
        id_o     = ITLB;
        if (eligible == 2'b11) begin
            id_o = (last_grant_q == DTLB) ? ITLB : DTLB;
        end else if (eligible[1]) begin
            id_o = DTLB;
        end
    end

    // Remember the winner only when the grant is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i && valid_o) begin
            last_grant_d = id_o;
        end
    end

    // Last-grant register; resets to DTLB so ITLB wins the first tie.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        // NOTE: non-blocking updates keep every flop sampling pre-edge values.
        if (!rsn_i) begin
            last_grant_q <= DTLB;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/segre_tlb_walker.sv
// Shared ITLB/DTLB miss walker: arbitrates misses, fetches one PTE per miss,
// fills the requesting TLB and sequences whole-TLB invalidation.
module segre_tlb_walker
    import segre_pkg::*;
#(
    parameter int VADDR_SIZE = segre_pkg::VADDR_SIZE,
    parameter int PADDR_SIZE = segre_pkg::PADDR_SIZE,
    parameter int ADDR_SIZE  = 32
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   flush_i,
    input  logic [ADDR_SIZE-1:0]   ptbr_i,
    input  logic                   itlb_miss_i,
    input  logic                   dtlb_miss_i,
    input  logic [VADDR_SIZE-1:0]  itlb_vaddr_i,
    input  logic [VADDR_SIZE-1:0]  dtlb_vaddr_i,
    output logic                   itlb_new_entry_o,
    output logic                   dtlb_new_entry_o,
    output logic                   itlb_invalidate_o,
    output logic                   dtlb_invalidate_o,
    output logic [VADDR_SIZE-1:0]  fill_vaddr_o,
    output logic [PADDR_SIZE-1:0]  fill_paddr_o,
    output page_protection_e       fill_prot_o,
    output logic                   itlb_done_o,
    output logic                   dtlb_done_o,
    output logic                   itlb_fault_o,
    output logic                   dtlb_fault_o,
    segre_tlb_walker_if.master     mem_if,
    output logic                   busy_o
);

    tlb_walker_state_e     state_q, state_d;
    tlb_req_id_e           id_q, id_d;
    logic [VADDR_SIZE-1:0] vaddr_q, vaddr_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [ADDR_SIZE-1:0]  pte_q, pte_d;
    logic                  flush_pending_q, flush_pending_d;
    logic [1:0]            mask_q, mask_d;

    logic                  arb_valid;
    tlb_req_id_e           arb_id;
    logic                  grant_accept;
    logic [VADDR_SIZE-1:0] sel_vaddr;
    logic                  pte_valid;
    logic                  in_fill;

    // Reserved PTE bits are deliberately ignored by the walker.
    logic unused_pte_bits;
    assign unused_pte_bits = ^pte_q;

    segre_rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rsn_i    (rsn_i),
        .req_i    ({dtlb_miss_i, itlb_miss_i}),
        .mask_i   (mask_q),
        .accept_i (grant_accept),
        .valid_o  (arb_valid),
        .id_o     (arb_id)
    );

    // Sticky flush request; a new flush in the clearing cycle keeps it set.
    always_comb begin
        flush_pending_d = flush_i | (flush_pending_q & (state_q != TW_FLUSH));
    end

    // Next-state logic: grant, PTE address capture and response capture.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        vaddr_d      = vaddr_q;
        addr_d       = addr_q;
        pte_d        = pte_q;
        mask_d       = 2'b00;
        grant_accept = 1'b0;
        sel_vaddr    = (arb_id == ITLB) ? itlb_vaddr_i : dtlb_vaddr_i;

        unique case (state_q)
            TW_IDLE: begin
                if (flush_pending_q) begin
                    state_d = TW_FLUSH;
                end else if (arb_valid) begin
                    grant_accept = 1'b1;
                    id_d         = arb_id;
                    vaddr_d      = sel_vaddr;
                    addr_d       = ptbr_i + (ADDR_SIZE'(sel_vaddr) << 2);
                    state_d      = TW_MEM_REQ;
                end
            end
            TW_MEM_REQ: begin
                if (mem_if.mem_gnt) begin
                    state_d = TW_MEM_WAIT;
                end
            end
            TW_MEM_WAIT: begin
                if (mem_if.mem_rvalid) begin
                    pte_d   = mem_if.mem_rdata;
                    state_d = TW_FILL;
                end
            end
            TW_FILL: begin
                // The served requester drops its miss a cycle late; hide it
                // from the arbiter for the first IDLE cycle.
                mask_d  = (id_q == ITLB) ? 2'b01 : 2'b10;
                state_d = TW_IDLE;
            end
            TW_FLUSH: begin
                state_d = TW_IDLE;
            end
            default: begin
                state_d = TW_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any walk in flight.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q         <= TW_IDLE;
            id_q            <= ITLB;
            vaddr_q         <= '0;
            addr_q          <= '0;
            pte_q           <= '0;
            flush_pending_q <= 1'b0;
            mask_q          <= 2'b00;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            vaddr_q         <= vaddr_d;
            addr_q          <= addr_d;
            pte_q           <= pte_d;
            flush_pending_q <= flush_pending_d;
            mask_q          <= mask_d;
        end
    end

    // Output decode from the state register and the latched walk data.
    always_comb begin
        in_fill           = (state_q == TW_FILL);
        pte_valid         = pte_q[PTE_VALID_BIT];
        itlb_done_o       = in_fill && (id_q == ITLB);
        dtlb_done_o       = in_fill && (id_q == DTLB);
        itlb_new_entry_o  = itlb_done_o && pte_valid;
        dtlb_new_entry_o  = dtlb_done_o && pte_valid;
        itlb_fault_o      = itlb_done_o && !pte_valid;
        dtlb_fault_o      = dtlb_done_o && !pte_valid;
        itlb_invalidate_o = (state_q == TW_FLUSH);
        dtlb_invalidate_o = (state_q == TW_FLUSH);
        fill_vaddr_o      = vaddr_q;
        fill_paddr_o      = pte_q[PADDR_SIZE-1:0];
        fill_prot_o       = page_protection_e'(pte_q[PTE_PROT_LSB +: 2]);
        mem_if.mem_req    = (state_q == TW_MEM_REQ);
        mem_if.mem_addr   = addr_q;
        busy_o            = (state_q != TW_IDLE);
    end

endmodule

// File: tb/tb_segre_tlb_walker.sv
// Self-checking bench for segre_tlb_walker: a scripted memory responder checks
// PTE addresses, a monitor pops expected fills from a scoreboard queue.
module tb_segre_tlb_walker;
    import segre_pkg::*;

    localparam int VW = segre_pkg::VADDR_SIZE;
    localparam int PW = segre_pkg::PADDR_SIZE;

    typedef struct {
        tlb_req_id_e      id;
        logic             fault;
        logic [VW-1:0]    vaddr;
        logic [PW-1:0]    paddr;
        page_protection_e prot;
    } fill_t;

    logic             clk;
    logic             rsn;
    logic             flush;
    logic [31:0]      ptbr;
    logic             itlb_miss, dtlb_miss;
    logic [VW-1:0]    itlb_vaddr, dtlb_vaddr;
    logic             i_new, d_new, i_inv, d_inv, i_done, d_done, i_fault, d_fault;
    logic [VW-1:0]    fill_vaddr;
    logic [PW-1:0]    fill_paddr;
    page_protection_e fill_prot;
    logic             busy;

    segre_tlb_walker_if #(.ADDR_SIZE(32)) mem_if ();

    segre_tlb_walker dut (
        .clk_i             (clk),
        .rsn_i             (rsn),
        .flush_i           (flush),
        .ptbr_i            (ptbr),
        .itlb_miss_i       (itlb_miss),
        .dtlb_miss_i       (dtlb_miss),
        .itlb_vaddr_i      (itlb_vaddr),
        .dtlb_vaddr_i      (dtlb_vaddr),
        .itlb_new_entry_o  (i_new),
        .dtlb_new_entry_o  (d_new),
        .itlb_invalidate_o (i_inv),
        .dtlb_invalidate_o (d_inv),
        .fill_vaddr_o      (fill_vaddr),
        .fill_paddr_o      (fill_paddr),
        .fill_prot_o       (fill_prot),
        .itlb_done_o       (i_done),
        .dtlb_done_o       (d_done),
        .itlb_fault_o      (i_fault),
        .dtlb_fault_o      (d_fault),
        .mem_if            (mem_if),
        .busy_o            (busy)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    fill_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pte_q[$];
    int          inval_q[$];
    int          i_done_cyc = 0;
    int          d_done_cyc = 0;
    int          i_drop = 0;
    int          d_drop = 0;
    int          gnt_delay = 0;
    int          rvalid_delay = 0;
    logic        hold_rvalid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters drop their miss one full cycle after the done pulse.
    initial forever begin
        @(posedge clk);
        #1;
        if (i_drop > 0) begin
            i_drop--;
            if (i_drop == 0) itlb_miss = 1'b0;
        end
        if (d_drop > 0) begin
            d_drop--;
            if (d_drop == 0) dtlb_miss = 1'b0;
        end
    end

    // Memory responder: grant after gnt_delay cycles, answer after rvalid_delay.
    initial begin
        logic [31:0] first_addr;
        logic [31:0] pend_data;
        logic        pend_rv;
        int          req_cycles;
        int          rv_wait;
        first_addr = '0;
        pend_data  = '0;
        pend_rv    = 1'b0;
        req_cycles = 0;
        rv_wait    = 0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_if.mem_gnt    = 1'b0;
            mem_if.mem_rvalid = 1'b0;
            if (pend_rv) begin
                if (!hold_rvalid) begin
                    if (rv_wait > 0) begin
                        rv_wait--;
                    end else begin
                        mem_if.mem_rvalid = 1'b1;
                        mem_if.mem_rdata  = pend_data;
                        pend_rv           = 1'b0;
                    end
                end
            end else if (rsn && mem_if.mem_req) begin
                if (req_cycles == 0) begin
                    check("mem_req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                    first_addr = mem_if.mem_addr;
                end else begin
                    check("mem_addr_stable", mem_if.mem_addr, first_addr);
                end
                if (req_cycles == gnt_delay) begin
                    mem_if.mem_gnt = 1'b1;
                    req_cycles     = 0;
                    if (exp_addr_q.size() != 0)
                        check("mem_addr", mem_if.mem_addr, exp_addr_q.pop_front());
                    pend_data = (exp_pte_q.size() != 0) ? exp_pte_q.pop_front() : 32'h0;
                    pend_rv   = 1'b1;
                    rv_wait   = rvalid_delay;
                end else begin
                    req_cycles++;
                end
            end else if (req_cycles != 0) begin
                check("mem_req_held", 32'(mem_if.mem_req), 32'd1);
                req_cycles = 0;
            end
        end
    end

    // Fill monitor: every done is matched against the head of the scoreboard.
    initial forever begin
        fill_t       e;
        tlb_req_id_e got_id;
        logic        ne, ft;
        @(negedge clk);
        if (rsn) begin
            if (i_done || d_done) begin
                got_id = d_done ? DTLB : ITLB;
                if (got_id == ITLB) begin
                    ne = i_new; ft = i_fault; i_done_cyc = cyc; i_drop = 2;
                end else begin
                    ne = d_new; ft = d_fault; d_done_cyc = cyc; d_drop = 2;
                end
                check("fill_expected", 32'(exp_q.size() != 0), 32'd1);
                check("done_onehot", 32'(i_done & d_done), 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("done_side", 32'(got_id), 32'(e.id));
                    check("fault", 32'(ft), 32'(e.fault));
                    check("new_entry", 32'(ne), 32'(!e.fault));
                    if (!e.fault) begin
                        check("fill_vaddr", 32'(fill_vaddr), 32'(e.vaddr));
                        check("fill_paddr", 32'(fill_paddr), 32'(e.paddr));
                        check("fill_prot", 32'(fill_prot), 32'(e.prot));
                    end
                end
            end else if (i_new || d_new || i_fault || d_fault) begin
                check("strobe_without_done", 32'({i_new, d_new, i_fault, d_fault}), 32'd0);
            end
            if (i_inv || d_inv) begin
                check("inval_pair", 32'({i_inv, d_inv}), 32'd3);
                inval_q.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_walk(input tlb_req_id_e id, input logic [VW-1:0] va,
                               input logic [31:0] addr, input logic [31:0] pte,
                               input logic [PW-1:0] pa, input page_protection_e prot,
                               input logic fault);
        fill_t e;
        e.id = id; e.fault = fault; e.vaddr = va; e.paddr = pa; e.prot = prot;
        exp_q.push_back(e);
        exp_addr_q.push_back(addr);
        exp_pte_q.push_back(pte);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({i_new, d_new, i_inv, d_inv, i_done, d_done,
                                      i_fault, d_fault, mem_if.mem_req, busy}), 32'd0);
        check({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
        check({tag, "_fill"}, 32'({fill_vaddr, fill_paddr, fill_prot}), 32'd0);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !itlb_miss && !dtlb_miss) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c;
        rsn = 1'b0; flush = 1'b0; ptbr = 32'h1000;
        itlb_miss = 1'b0; dtlb_miss = 1'b0; itlb_vaddr = '0; dtlb_vaddr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rsn = 1'b1;
        @(negedge clk);

        // First tie after reset: ITLB wins, then DTLB.
        expect_walk(ITLB, 20'h12345, 32'h0004_9D14, 32'hC001_2345, 20'h12345, PROT_RX, 1'b0);
        expect_walk(DTLB, 20'h00FF0, 32'h0000_4FC0, 32'hA00A_BCDE, 20'hABCDE, PROT_R, 1'b0);
        itlb_vaddr = 20'h12345; dtlb_vaddr = 20'h00FF0;
        itlb_miss = 1'b1; dtlb_miss = 1'b1;
        wait_idle();

        // Single I-miss with immediate memory: done three cycles after the miss.
        expect_walk(ITLB, 20'h0000A, 32'h0000_1028, 32'h8000_000A, 20'h0000A, PROT_RW, 1'b0);
        itlb_vaddr = 20'h0000A; itlb_miss = 1'b1; c = cyc;
        wait_idle();
        check("i_miss_latency", 32'(i_done_cyc - c), 32'd3);

        // Second tie, ITLB served last: DTLB goes first.
        expect_walk(DTLB, 20'h00001, 32'h0000_1004, 32'h8000_0777, 20'h00777, PROT_RW, 1'b0);
        expect_walk(ITLB, 20'hFFFFF, 32'h0040_0FFC, 32'hE00F_FFFF, 20'hFFFFF, PROT_NONE, 1'b0);
        itlb_vaddr = 20'hFFFFF; dtlb_vaddr = 20'h00001;
        itlb_miss = 1'b1; dtlb_miss = 1'b1;
        wait_idle();

        // Invalid PTE on a D-miss: done and fault, no new entry.
        expect_walk(DTLB, 20'h00042, 32'h0000_1108, 32'h7FFF_FFFF, 20'h0, PROT_RW, 1'b1);
        dtlb_vaddr = 20'h00042; dtlb_miss = 1'b1;
        wait_idle();

        // Flush in IDLE, then a second flush in the FLUSH cycle itself.
        inval_q.delete();
        flush = 1'b1; c = cyc;
        @(negedge clk); flush = 1'b0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        wait_idle();
        check("flush_count", 32'(inval_q.size()), 32'd2);
        if (inval_q.size() >= 2) begin
            check("flush1_latency", 32'(inval_q[0] - c), 32'd2);
            check("flush2_latency", 32'(inval_q[1] - c), 32'd4);
        end

        // Flush and D-miss arrive while an I-walk waits for memory.
        inval_q.delete();
        rvalid_delay = 3;
        expect_walk(ITLB, 20'h00010, 32'h0000_1040, 32'h8000_0010, 20'h00010, PROT_RW, 1'b0);
        expect_walk(DTLB, 20'h00020, 32'h0000_1080, 32'hC000_0020, 20'h00020, PROT_RX, 1'b0);
        itlb_vaddr = 20'h00010; itlb_miss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_in_walk", 32'(busy), 32'd1);
        flush = 1'b1; dtlb_vaddr = 20'h00020; dtlb_miss = 1'b1; rvalid_delay = 0;
        @(negedge clk); flush = 1'b0;
        wait_idle();
        check("walk_flush_count", 32'(inval_q.size()), 32'd1);
        if (inval_q.size() >= 1) begin
            check("flush_after_fill", 32'(inval_q[0] - i_done_cyc), 32'd2);
            check("d_after_flush", 32'(d_done_cyc - inval_q[0]), 32'd4);
        end

        // Grant stalled five cycles: request and address must hold.
        gnt_delay = 5;
        expect_walk(DTLB, 20'h00003, 32'h0000_100C, 32'hA000_0003, 20'h00003, PROT_R, 1'b0);
        dtlb_vaddr = 20'h00003; dtlb_miss = 1'b1;
        wait_idle();
        gnt_delay = 0;

        // Reset in MEM_WAIT: outputs clear at once, a stale response is ignored.
        hold_rvalid = 1'b1;
        exp_addr_q.push_back(32'h0000_1014);
        exp_pte_q.push_back(32'h8000_0005);
        itlb_vaddr = 20'h00005; itlb_miss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        rsn = 1'b0; itlb_miss = 1'b0;
        #1;
        check_all_zero("reset_midwalk");
        @(negedge clk); rsn = 1'b1;
        @(negedge clk); hold_rvalid = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_after_stale_rvalid", 32'(busy), 32'd0);

        // After reset the first tie again goes to ITLB; new ptbr sampled at grant.
        ptbr = 32'h0002_0000;
        expect_walk(ITLB, 20'h00006, 32'h0002_0018, 32'h8000_0006, 20'h00006, PROT_RW, 1'b0);
        expect_walk(DTLB, 20'h00007, 32'h0002_001C, 32'hA000_0007, 20'h00007, PROT_R, 1'b0);
        itlb_vaddr = 20'h00006; dtlb_vaddr = 20'h00007;
        itlb_miss = 1'b1; dtlb_miss = 1'b1;
        wait_idle();
        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
